// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sharing of one fixed-latency multiplier with credit-limited in-order response FIFO
module mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 32,
  parameter int MUL_LAT = 3,
  parameter int RSP_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       mul_valid_o,
  output logic [DATA_W-1:0]          mul_a_o,
  output logic [DATA_W-1:0]          mul_b_o,
  input  logic                       mul_valid_i,
  input  logic [DATA_W-1:0]          mul_result_i,
  output logic                       rsp_valid_o,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  input  logic                       rsp_ready_i,
  output logic                       busy_o,
  output logic                       err_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int AW = $clog2(RSP_DEPTH);
  logic [CW-1:0] credit_cnt, fifo_cnt;
  logic [IW-1:0] rr_ptr, gnt_id, cand, iss_id;
  logic [MUL_LAT-1:0] tag_v;
  logic [IW-1:0] tag_id [MUL_LAT];
  logic [DATA_W-1:0] mem_d [RSP_DEPTH];
  logic [IW-1:0] mem_id [RSP_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic fire, tag_out, push, pop, miss;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(RSP_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    gnt_id = rr_ptr;
    cand = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid_i[cand]) gnt_id = cand;
    end
  end

  assign req_ready_o = (rst_n_i && credit_cnt < CW'(RSP_DEPTH) && |req_valid_i) ? NUM_REQ'(1) << gnt_id : '0;
  assign fire = |req_ready_o;
  assign tag_out = tag_v[MUL_LAT-1];
  assign push = tag_out & mul_valid_i;
  assign miss = tag_out & ~mul_valid_i;
  assign rsp_valid_o = fifo_cnt != '0;
  assign pop = rsp_valid_o & rsp_ready_i;
  assign rsp_data_o = mem_d[rd_ptr];
  assign rsp_id_o = mem_id[rd_ptr];
  assign busy_o = credit_cnt != '0;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      credit_cnt <= '0;
      rr_ptr <= IW'(NUM_REQ - 1);
      iss_id <= '0;
      mul_valid_o <= 1'b0;
      mul_a_o <= '0;
      mul_b_o <= '0;
      tag_v <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_cnt <= '0;
      err_o <= 1'b0;
      for (int i = 0; i < MUL_LAT; i++) tag_id[i] <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_id[i] <= '0;
      end
    end else begin
      credit_cnt <= credit_cnt + CW'(fire) - CW'(pop) - CW'(miss);
      mul_valid_o <= fire;
      if (fire) begin
        mul_a_o <= req_a_i[gnt_id*DATA_W +: DATA_W];
        mul_b_o <= req_b_i[gnt_id*DATA_W +: DATA_W];
        rr_ptr <= gnt_id;
        iss_id <= gnt_id;
      end
      tag_v[0] <= mul_valid_o;
      tag_id[0] <= iss_id;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      if (push) begin
        mem_d[wr_ptr] <= mul_result_i;
        mem_id[wr_ptr] <= tag_id[MUL_LAT-1];
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      err_o <= err_o | (mul_valid_i != tag_out);
    end
  end
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed bench with a transaction-level model checking two arbiter instances every cycle
module tb_mul_share_arb;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int LAT = 3;
  localparam int MAXC = 1024;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, rsp_ready, flip;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_a, req_b;
  logic [NR-1:0] req_ready [2];
  logic mvo [2], mvi [2], rsp_v [2], busy [2], err [2];
  logic [DW-1:0] mao [2], mbo [2], mres [2], rsp_d [2];
  logic [1:0] rsp_id [2];
  int c, vecs, errs, last_rst, exp_l, f0, f1;
  bit model_ok;
  int fires [2], cred [2], last [2], rh [2], rt [2];
  logic emv [2], eerr [2];
  logic [31:0] ema [2], emb [2];
  logic [1:0] rqi [2][64];
  logic [31:0] rqd [2][64];
  logic tv [2][MAXC];
  logic [1:0] tid [2][MAXC];
  logic [31:0] tpr [2][MAXC];
  logic hv [2][MAXC];
  logic [31:0] ha [2][MAXC], hb [2][MAXC];

  mul_share_arb #(.NUM_REQ(NR), .DATA_W(DW), .MUL_LAT(LAT), .RSP_DEPTH(4)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready[0]), .mul_valid_o(mvo[0]), .mul_a_o(mao[0]), .mul_b_o(mbo[0]),
    .mul_valid_i(mvi[0]), .mul_result_i(mres[0]), .rsp_valid_o(rsp_v[0]), .rsp_data_o(rsp_d[0]),
    .rsp_id_o(rsp_id[0]), .rsp_ready_i(rsp_ready), .busy_o(busy[0]), .err_o(err[0]));
  mul_share_arb #(.NUM_REQ(NR), .DATA_W(DW), .MUL_LAT(LAT), .RSP_DEPTH(6)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready[1]), .mul_valid_o(mvo[1]), .mul_a_o(mao[1]), .mul_b_o(mbo[1]),
    .mul_valid_i(mvi[1]), .mul_result_i(mres[1]), .rsp_valid_o(rsp_v[1]), .rsp_data_o(rsp_d[1]),
    .rsp_id_o(rsp_id[1]), .rsp_ready_i(rsp_ready), .busy_o(busy[1]), .err_o(err[1]));

  function automatic int dep(int d);
    return d == 0 ? 4 : 6;
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] p;
    logic [9:0] e;
    p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = {2'b0, x[30:23]} + {2'b0, y[30:23]} - 10'd127;
    if (p[47]) begin
      p = p >> 1;
      e = e + 10'd1;
    end
    return {x[31] ^ y[31], e[7:0], p[45:23]};
  endfunction

  function automatic int pick(int d);
    int k;
    for (int i = 1; i <= NR; i++) begin
      k = (last[d] + i) % NR;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, c, act, exp);
    end
  endtask

  task automatic set_ops();
    for (int k = 0; k < NR; k++) begin
      req_a[k*DW +: DW] = {1'b0, 8'(120 + (c + k) % 8), 23'(c * 977 + k * 131)};
      req_b[k*DW +: DW] = {1'b0, 8'(126 + k % 3), 23'(c * 31 + k * 4099)};
    end
  endtask

  task automatic cyc();
    int s, g;
    logic [3:0] er;
    logic tg;
    bit pp, ps, ms;
    for (int d = 0; d < 2; d++) begin
      s = c - LAT;
      mvi[d] = ((s >= 0 && last_rst < s) ? hv[d][s] : 1'b0) ^ flip;
      mres[d] = s >= 0 ? fmul(ha[d][s], hb[d][s]) : 32'h0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      g = (rst_n && cred[d] < dep(d)) ? pick(d) : -1;
      er = g < 0 ? 4'b0 : 4'(1 << g);
      chk("req_ready", d, 32'(req_ready[d]), 32'(er));
      if (model_ok) begin
        chk("mul_valid", d, 32'(mvo[d]), 32'(emv[d]));
        chk("mul_a", d, mao[d], ema[d]);
        chk("mul_b", d, mbo[d], emb[d]);
        chk("rsp_valid", d, 32'(rsp_v[d]), 32'(rt[d] != rh[d]));
        if (rt[d] != rh[d]) begin
          chk("rsp_data", d, rsp_d[d], rqd[d][rh[d] % 64]);
          chk("rsp_id", d, 32'(rsp_id[d]), 32'(rqi[d][rh[d] % 64]));
        end
        chk("busy", d, 32'(busy[d]), 32'(cred[d] != 0));
        chk("err", d, 32'(err[d]), 32'(eerr[d]));
      end
      hv[d][c] = mvo[d];
      ha[d][c] = mao[d];
      hb[d][c] = mbo[d];
      fires[d] += $countones(req_ready[d] & req_valid);
      if (!rst_n) begin
        cred[d] = 0;
        last[d] = NR - 1;
        emv[d] = 1'b0;
        ema[d] = '0;
        emb[d] = '0;
        eerr[d] = 1'b0;
        rh[d] = 0;
        rt[d] = 0;
        for (int i = c + 1; i <= c + LAT + 2; i++) tv[d][i] = 1'b0;
      end else begin
        tg = tv[d][c];
        pp = rt[d] != rh[d] && rsp_ready;
        ps = tg && mvi[d];
        ms = tg && !mvi[d];
        eerr[d] = eerr[d] | (tg != mvi[d]);
        if (pp) rh[d]++;
        if (ps) begin
          rqd[d][rt[d] % 64] = tpr[d][c];
          rqi[d][rt[d] % 64] = tid[d][c];
          rt[d]++;
        end
        emv[d] = g >= 0;
        if (g >= 0) begin
          ema[d] = req_a[g*DW +: DW];
          emb[d] = req_b[g*DW +: DW];
          last[d] = g;
          tv[d][c+1+LAT] = 1'b1;
          tid[d][c+1+LAT] = 2'(g);
          tpr[d][c+1+LAT] = fmul(ema[d], emb[d]);
        end
        cred[d] = cred[d] + int'(g >= 0) - int'(pp) - int'(ms);
      end
    end
    if (!rst_n) begin
      last_rst = c;
      model_ok = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    c++;
  endtask

  task automatic chk_reset_vals(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_mvalid"}, d, 32'(mvo[d]), 32'd0);
      chk({nm, "_ma"}, d, mao[d], 32'd0);
      chk({nm, "_mb"}, d, mbo[d], 32'd0);
      chk({nm, "_rspv"}, d, 32'(rsp_v[d]), 32'd0);
      chk({nm, "_rspd"}, d, rsp_d[d], 32'd0);
      chk({nm, "_rspid"}, d, 32'(rsp_id[d]), 32'd0);
      chk({nm, "_busy"}, d, 32'(busy[d]), 32'd0);
      chk({nm, "_err"}, d, 32'(err[d]), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs = 0; errs = 0; c = 0; last_rst = -100; model_ok = 1'b0; flip = 1'b0;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      fires[d] = 0; cred[d] = 0; last[d] = NR - 1; rh[d] = 0; rt[d] = 0;
      for (int i = 0; i < MAXC; i++) tv[d][i] = 1'b0;
    end
    @(negedge clk);
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    chk_reset_vals("rst");
    rsp_ready = 1'b1;
    req_a[2*DW +: DW] = 32'h40400000;
    req_b[2*DW +: DW] = 32'h40000000;
    req_valid = 4'b0100;
    #1;
    for (int d = 0; d < 2; d++) chk("t1_grant", d, 32'(req_ready[d]), 32'h4);
    cyc();
    req_valid = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("t1_mvalid", d, 32'(mvo[d]), 32'd1);
      chk("t1_ma", d, mao[d], 32'h40400000);
    end
    cyc();
    repeat (2) cyc();
    #1;
    for (int d = 0; d < 2; d++) chk("t1_early", d, 32'(rsp_v[d]), 32'd0);
    cyc();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("t1_rspv", d, 32'(rsp_v[d]), 32'd1);
      chk("t1_rspd", d, rsp_d[d], 32'h40C00000);
      chk("t1_rspid", d, 32'(rsp_id[d]), 32'd2);
    end
    repeat (4) cyc();
    exp_l = 3;
    for (int i = 0; i < 24; i++) begin
      set_ops();
      req_valid = 4'hF;
      #1;
      chk("t2_fullrate", 1, 32'(req_ready[1]), 32'(1 << exp_l));
      exp_l = (exp_l + 1) % NR;
      cyc();
    end
    req_valid = '0;
    repeat (10) cyc();
    rsp_ready = 1'b0;
    f0 = fires[0];
    f1 = fires[1];
    for (int i = 0; i < 10; i++) begin
      set_ops();
      req_valid = 4'b0011;
      cyc();
    end
    #1;
    chk("t3_issues", 0, 32'(fires[0] - f0), 32'd4);
    chk("t3_issues", 1, 32'(fires[1] - f1), 32'd6);
    chk("t3_stall", 0, 32'(req_ready[0]), 32'd0);
    chk("t3_busy", 0, 32'(busy[0]), 32'd1);
    rsp_ready = 1'b1;
    #1;
    chk("t3_hold", 0, 32'(req_ready[0]), 32'd0);
    cyc();
    set_ops();
    #1;
    chk("t3_regrant", 0, 32'(req_ready[0] != '0), 32'd1);
    for (int i = 0; i < 12; i++) begin
      set_ops();
      cyc();
    end
    req_valid = '0;
    repeat (10) cyc();
    for (int i = 0; i < 30; i++) begin
      set_ops();
      req_valid = 4'hF;
      rsp_ready = (c % 3) != 0;
      cyc();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (12) cyc();
    flip = 1'b1;
    cyc();
    flip = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("t5_spur_err", d, 32'(err[d]), 32'd1);
      chk("t5_spur_rspv", d, 32'(rsp_v[d]), 32'd0);
    end
    repeat (3) cyc();
    #1;
    for (int d = 0; d < 2; d++) chk("t5_sticky", d, 32'(err[d]), 32'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("t5_clr", d, 32'(err[d]), 32'd0);
    set_ops();
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    repeat (3) cyc();
    flip = 1'b1;
    cyc();
    flip = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("t5_drop_err", d, 32'(err[d]), 32'd1);
      chk("t5_drop_busy", d, 32'(busy[d]), 32'd0);
      chk("t5_drop_rspv", d, 32'(rsp_v[d]), 32'd0);
    end
    repeat (4) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_ops();
      req_valid = 4'hF;
      cyc();
    end
    req_valid = '0;
    cyc();
    #1;
    chk("t6_buffered", 1, 32'(rsp_v[1]), 32'd1);
    chk("t6_busy", 1, 32'(busy[1]), 32'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk_reset_vals("t6");
    rsp_ready = 1'b1;
    repeat (10) cyc();
    set_ops();
    req_valid = 4'b1000;
    cyc();
    req_valid = '0;
    repeat (8) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and sequencer that shares one fixed-latency, non-stallable floating-point multiplier (Booth partial products + Wallace reduction + final adder) between NUM_REQ dot-product lanes. Accepts operand pairs over valid/ready, issues at most one pair per cycle to the multiplier, tracks each in-flight product with a requester tag, and returns results in issue order through a response FIFO. Credit-based issue control ensures a product leaving the multiplier always has a FIFO slot, so the datapath never needs to stall.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/result width
- MUL_LAT, 3, cycles from mul_valid_o to the matching mul_valid_i (>=1)
- RSP_DEPTH, 4, response FIFO entries; also the issue credit limit (>=2)
- clk_i  in  1  single clock; all logic on rising edge
- rst_n_i  in  1  synchronous, active-low reset
- req_valid_i  in  NUM_REQ  per-lane request valid
- req_a_i  in  NUM_REQ*DATA_W  lane k operand A at [k*DATA_W +: DATA_W]
- req_b_i  in  NUM_REQ*DATA_W  lane k operand B, same packing
- req_ready_o  out  NUM_REQ  one-hot grant (combinational)
- mul_valid_o  out  1  operand pair valid to multiplier (registered)
- mul_a_o, mul_b_o  out  DATA_W  operands to multiplier (registered)
- mul_valid_i  in  1  product valid from multiplier
- mul_result_i  in  DATA_W  product
- rsp_valid_o  out  1  response FIFO non-empty
- rsp_data_o  out  DATA_W  head product
- rsp_id_o  out  clog2(NUM_REQ)  requester index of head product
- rsp_ready_i  in  1  consumer pops head when rsp_valid_o & rsp_ready_i
- busy_o  out  1  credit_cnt != 0
- err_o  out  1  sticky protocol error

## Operation
- Credit counter credit_cnt, width clog2(RSP_DEPTH+1): +1 on issue, -1 on pop, unchanged when both. Counts the issue register, tag pipe and FIFO occupancy.
- can_issue = credit_cnt < RSP_DEPTH, from the registered value; a pop in the same cycle does not free a credit until the next cycle.
- Arbitration: rr_ptr holds last granted index. When can_issue, grant the first k with req_valid_i[k] set, searching rr_ptr+1, rr_ptr+2, … cyclically; req_ready_o = one-hot of that k, else all zero. req_ready_o never depends on rsp_ready_i.
- Handshake on lane k = req_valid_i[k] & req_ready_o[k]: latch mul_a_o/mul_b_o from lane k, set mul_valid_o next cycle, rr_ptr <= k, credit_cnt++. With no issue, mul_valid_o <= 0; mul_a_o/mul_b_o hold.
- Tag pipe: MUL_LAT-stage shift register of {valid, id}, stage 0 loaded from {mul_valid_o, id of issued pair}. Output stage aligns with mul_valid_i.
- On tag-out valid: push {mul_result_i, id} into FIFO. Overflow is impossible by credit rule.
- err_o set (sticky until reset) when mul_valid_i != tag-out valid. A mismatched product is dropped; a missing product pushes nothing. The credit is freed in either case (decrement on tag-out valid with no push).
- FIFO: RSP_DEPTH entries, registered head; simultaneous push and pop allowed at any occupancy, including full (pop frees slot) and empty (no bypass).
- The multiplier pipeline is reset by the same rst_n_i, so no stale products follow reset.

## Timing
- Reset (rst_n_i low at edge): credit_cnt=0, rr_ptr=NUM_REQ-1 (lane 0 first), tag pipe cleared, FIFO empty. Outputs: mul_valid_o=0, mul_a_o=mul_b_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, busy_o=0, err_o=0. req_ready_o=0 while rst_n_i is low.
- Reset mid-operation discards all in-flight and buffered products.
- Handshake at edge T: mul_valid_o high in cycle T+1. mul_valid_i expected in cycle T+1+MUL_LAT. rsp_valid_o high in cycle T+2+MUL_LAT. Minimum accept-to-response latency is MUL_LAT+2.
- Throughput: one issue per cycle while credits allow. Steady-state full rate requires RSP_DEPTH >= MUL_LAT+2 with rsp_ready_i held high.
- Responses return in global issue order, never reordered per lane.

## Test plan
- Single request, lane 2, A=3.0 (0x40400000), B=2.0, MUL_LAT=3 → req_ready_o=4'b0100 same cycle, mul_valid_o next cycle, rsp_valid_o 5 cycles after accept with rsp_data_o=0x40C00000 (6.0) and rsp_id_o=2.
- All 4 lanes valid continuously, rsp_ready_i=1, RSP_DEPTH=6 → grants cycle 0,1,2,3,0,…, one per cycle, no gaps. rsp_id_o sequence matches grant order.
- rsp_ready_i=0 with lanes 0 and 1 valid, RSP_DEPTH=4 → exactly 4 issues, then req_ready_o=0, busy_o=1. Raise rsp_ready_i: first pop, then a new grant one cycle later. FIFO never exceeds 4 entries.
- FIFO full with push and pop in the same cycle → occupancy stays 4, data order preserved, no lost or duplicate rsp_id_o.
- Inject a spurious mul_valid_i with an empty tag pipe → err_o rises next cycle and stays high, FIFO unchanged. Drop an expected mul_valid_i → err_o set, credit_cnt returns to 0 after the drain.
- Assert rst_n_i low for one cycle with 3 products in flight and 2 buffered → all outputs return to reset values next cycle, busy_o=0, no response appears afterwards. A new request completes normally.
